// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Branch-resolution controller for the pipelined OTTER.
//   - Holds a table of 2-bit saturating counters (BHT) that fetch reads to
//     predict conditional branches.
//   - In EX, works out the real branch outcome from funct3 and the comparator
//     flags, spots mispredicts, and runs a multi-cycle flush/redirect of IF/ID.
//   - Counts resolved branches and mispredicts.
//
// Ports:
//   CLK, RST           clock and synchronous active-high reset
//   if_pc              fetch PC used for the BHT lookup
//   if_pred_taken      combinational prediction (MSB of the indexed counter)
//   ex_valid           EX stage holds a valid instruction
//   ex_is_branch       EX instruction is a conditional branch
//   ex_funct3          branch funct3
//   ex_pc              PC of the EX instruction (selects the BHT entry to train)
//   ex_pred_taken      prediction that travelled down the pipe with the branch
//   br_eq/br_lt/br_ltu comparator flags (equal, signed less, unsigned less)
//   flush_o            registered squash of IF/ID, FLUSH_CYCLES cycles long
//   redirect_o         registered one-cycle pulse: reload the PC
//   redirect_taken_o   registered redirect source, 1 = target, 0 = ex_pc+4
//   illegal_o          registered one-cycle pulse: funct3 010/011 on a branch
//   branch_cnt         legal branches resolved (wraps)
//   mispred_cnt        mispredicts (wraps)

module branch_resolve_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output logic        flush_o,
  output logic        redirect_o,
  output logic        redirect_taken_o,
  output logic        illegal_o,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         flush_cnt;
  logic [2:0]         flush_cnt_nxt;
  logic               redirect_nxt;
  logic               redirect_taken_nxt;
  logic               illegal_nxt;

  logic [1:0]         bht [BHT_ENTRIES];
  logic [1:0]         bht_cur;
  logic [1:0]         bht_nxt;
  logic [IDX_W-1:0]   if_idx;
  logic [IDX_W-1:0]   ex_idx;

  logic               resolve;
  logic               legal;
  logic               taken;
  logic               legal_resolve;
  logic               mispredict;

  // PC bits outside the word-aligned index field play no part in prediction.
  logic               unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                            ex_pc[31:IDX_W+2], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Lookup reads the stored counter directly, so a same-cycle update to the
  // same entry is only visible from the next cycle on.
  assign if_pred_taken = bht[if_idx][1];

  // Branches arriving while a flush is running are on the wrong path and are
  // dropped completely.
  assign resolve = ex_valid & ex_is_branch & (state == IDLE);

  // Actual outcome from funct3. 010/011 are not valid branch encodings: they
  // resolve as not-taken but must not train the BHT or count as branches.
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (ex_funct3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: legal = 1'b0;
    endcase
  end

  assign legal_resolve = resolve & legal;
  assign mispredict    = legal_resolve & (taken != ex_pred_taken);

  // Saturating 2-bit counter step for the entry being trained.
  always_comb begin
    bht_cur = bht[ex_idx];
    bht_nxt = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (legal_resolve) begin
      bht[ex_idx] <= bht_nxt;
    end
  end

  // Next-state logic. flush_cnt is loaded with FLUSH_CYCLES-1 on entry and
  // FLUSH is left on the cycle it reads 0, giving exactly FLUSH_CYCLES
  // flush cycles. The redirect source is held between redirects.
  always_comb begin
    state_nxt          = state;
    flush_cnt_nxt      = flush_cnt;
    redirect_nxt       = 1'b0;
    redirect_taken_nxt = redirect_taken_o;
    illegal_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (resolve && !legal) illegal_nxt = 1'b1;
        if (mispredict) begin
          state_nxt          = FLUSH;
          flush_cnt_nxt      = 3'(FLUSH_CYCLES - 1);
          redirect_nxt       = 1'b1;
          redirect_taken_nxt = taken;
        end
      end
      FLUSH: begin
        if (flush_cnt == 3'd0) state_nxt = IDLE;
        else                   flush_cnt_nxt = flush_cnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      flush_cnt        <= 3'd0;
      flush_o          <= 1'b0;
      redirect_o       <= 1'b0;
      redirect_taken_o <= 1'b0;
      illegal_o        <= 1'b0;
    end else begin
      state            <= state_nxt;
      flush_cnt        <= flush_cnt_nxt;
      flush_o          <= (state_nxt == FLUSH);
      redirect_o       <= redirect_nxt;
      redirect_taken_o <= redirect_taken_nxt;
      illegal_o        <= illegal_nxt;
    end
  end

  // Statistics counters wrap naturally at 16 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      branch_cnt  <= 16'd0;
      mispred_cnt <= 16'd0;
    end else begin
      if (legal_resolve) branch_cnt  <= branch_cnt + 16'd1;
      if (mispredict)    mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl
// Directed bench for branch_resolve_ctrl with the default parameters
// (16 BHT entries, 2 flush cycles). A table of per-cycle vectors drives the
// EX/IF inputs; after each rising edge the registered outputs, counters and
// the prediction for the same PC are compared with hand-computed values.
// Hand-written sequences cover same-cycle lookup vs update, reset in the
// middle of a flush, and counter wrap.

module tb_branch_resolve_ctrl;

  logic        CLK;
  logic        RST;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        flush_o;
  logic        redirect_o;
  logic        redirect_taken_o;
  logic        illegal_o;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic        v;
    logic        b;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic        pred;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        e_flush;
    logic        e_redir;
    logic        e_rt;
    logic        e_ill;
    logic [15:0] e_bcnt;
    logic [15:0] e_mcnt;
    logic        e_p;
  } vec_t;

  vec_t vecs[$];

  branch_resolve_ctrl dut (
    .CLK              (CLK),
    .RST              (RST),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_funct3        (ex_funct3),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .br_eq            (br_eq),
    .br_lt            (br_lt),
    .br_ltu           (br_ltu),
    .flush_o          (flush_o),
    .redirect_o       (redirect_o),
    .redirect_taken_o (redirect_taken_o),
    .illegal_o        (illegal_o),
    .branch_cnt       (branch_cnt),
    .mispred_cnt      (mispred_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic v, input logic b, input logic [2:0] f3,
                              input logic [31:0] pc, input logic pred,
                              input logic eq, input logic lt, input logic ltu,
                              input logic fl, input logic rd, input logic rt,
                              input logic il, input logic [15:0] bc,
                              input logic [15:0] mc, input logic p);
    vec_t r;
    r.v = v; r.b = b; r.f3 = f3; r.pc = pc; r.pred = pred;
    r.eq = eq; r.lt = lt; r.ltu = ltu;
    r.e_flush = fl; r.e_redir = rd; r.e_rt = rt; r.e_ill = il;
    r.e_bcnt = bc; r.e_mcnt = mc; r.e_p = p;
    return r;
  endfunction

  // One vector per cycle; the fetch PC follows the EX PC so the post-edge
  // prediction shows the entry just trained.
  task automatic applyStimulus(input vec_t s);
    ex_valid      = s.v;
    ex_is_branch  = s.b;
    ex_funct3     = s.f3;
    ex_pc         = s.pc;
    if_pc         = s.pc;
    ex_pred_taken = s.pred;
    br_eq         = s.eq;
    br_lt         = s.lt;
    br_ltu        = s.ltu;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_funct3 = 3'b000;
    ex_pc = 32'h0; ex_pred_taken = 1'b0;
    br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
  endtask

  initial begin
    //          v  b  f3      pc      pr eq lt lu   fl rd rt il  bcnt mcnt p
    // Mispredicted BEQ, then the two flush cycles.
    vecs.push_back(mk(1, 1, 3'b000, 32'h100, 0, 1, 0, 0,  1, 1, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h100, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h100, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1));
    // BLTU not taken twice (01->00->00), then taken (00->01, still predicts NT).
    vecs.push_back(mk(1, 1, 3'b110, 32'h104, 0, 0, 1, 0,  0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(1, 1, 3'b110, 32'h104, 0, 0, 1, 0,  0, 0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(1, 1, 3'b110, 32'h104, 1, 0, 0, 1,  0, 0, 0, 0, 4, 1, 0));
    // BGE taken three times at 0x108: 01->10 (mispredict), ->11, ->11.
    vecs.push_back(mk(1, 1, 3'b101, 32'h108, 0, 0, 0, 0,  1, 1, 1, 0, 5, 2, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h108, 0, 0, 0, 0,  1, 0, 0, 0, 5, 2, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h108, 0, 0, 0, 0,  0, 0, 0, 0, 5, 2, 1));
    vecs.push_back(mk(1, 1, 3'b101, 32'h108, 1, 0, 0, 0,  0, 0, 0, 0, 6, 2, 1));
    vecs.push_back(mk(1, 1, 3'b101, 32'h108, 1, 0, 0, 0,  0, 0, 0, 0, 7, 2, 1));
    // Not-taken BGE: 11->10, redirect to fall-through.
    vecs.push_back(mk(1, 1, 3'b101, 32'h108, 1, 0, 1, 0,  1, 1, 0, 0, 8, 3, 1));
    // Resolves on both flush cycles are dropped; the next one counts.
    vecs.push_back(mk(1, 1, 3'b000, 32'h10C, 0, 1, 0, 0,  1, 0, 0, 0, 8, 3, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h10C, 0, 1, 0, 0,  0, 0, 0, 0, 8, 3, 0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h10C, 1, 1, 0, 0,  0, 0, 0, 0, 9, 3, 1));
    // Illegal funct3 010 and 011: pulse, no flush, no counting.
    vecs.push_back(mk(1, 1, 3'b010, 32'h110, 0, 1, 0, 0,  0, 0, 0, 1, 9, 3, 0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h110, 0, 0, 0, 0,  0, 0, 0, 0, 9, 3, 0));
    vecs.push_back(mk(1, 1, 3'b011, 32'h110, 1, 0, 0, 0,  0, 0, 0, 1, 9, 3, 0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h110, 0, 0, 0, 0,  0, 0, 0, 0, 9, 3, 0));
    // Gated by ex_valid and ex_is_branch.
    vecs.push_back(mk(0, 1, 3'b000, 32'h110, 0, 1, 0, 0,  0, 0, 0, 0, 9, 3, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h110, 0, 1, 0, 0,  0, 0, 0, 0, 9, 3, 0));
    // BNE taken mispredict; BLT and BGEU predicted correctly.
    vecs.push_back(mk(1, 1, 3'b001, 32'h114, 0, 0, 0, 0,  1, 1, 1, 0, 10, 4, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h114, 0, 0, 0, 0,  1, 0, 0, 0, 10, 4, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h114, 0, 0, 0, 0,  0, 0, 0, 0, 10, 4, 1));
    vecs.push_back(mk(1, 1, 3'b100, 32'h118, 1, 0, 1, 0,  0, 0, 0, 0, 11, 4, 1));
    vecs.push_back(mk(1, 1, 3'b111, 32'h11C, 1, 0, 0, 0,  0, 0, 0, 0, 12, 4, 1));
    // Mispredict, a dropped resolve in the last flush cycle, then a
    // mispredict in the first IDLE cycle is handled normally.
    vecs.push_back(mk(1, 1, 3'b000, 32'h100, 1, 0, 0, 0,  1, 1, 0, 0, 13, 5, 0));
    vecs.push_back(mk(0, 0, 3'b000, 32'h100, 0, 0, 0, 0,  1, 0, 0, 0, 13, 5, 0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h100, 0, 1, 0, 0,  0, 0, 0, 0, 13, 5, 0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h100, 0, 1, 0, 0,  1, 1, 1, 0, 14, 6, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h100, 0, 0, 0, 0,  1, 0, 0, 0, 14, 6, 1));
    vecs.push_back(mk(0, 0, 3'b000, 32'h100, 0, 0, 0, 0,  0, 0, 0, 0, 14, 6, 1));

    // Reset and check the reset state.
    RST = 1'b1;
    if_pc = 32'h100;
    idleInputs();
    step();
    step();
    RST = 1'b0;
    checkOutput("reset flush_o",     32'(flush_o),       32'd0);
    checkOutput("reset redirect_o",  32'(redirect_o),    32'd0);
    checkOutput("reset illegal_o",   32'(illegal_o),     32'd0);
    checkOutput("reset branch_cnt",  32'(branch_cnt),    32'd0);
    checkOutput("reset mispred_cnt", 32'(mispred_cnt),   32'd0);
    checkOutput("reset pred 0x100",  32'(if_pred_taken), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("row%0d flush_o", i),     32'(flush_o),       32'(vecs[i].e_flush));
      checkOutput($sformatf("row%0d redirect_o", i),  32'(redirect_o),    32'(vecs[i].e_redir));
      if (vecs[i].e_redir)
        checkOutput($sformatf("row%0d redirect_taken_o", i), 32'(redirect_taken_o), 32'(vecs[i].e_rt));
      checkOutput($sformatf("row%0d illegal_o", i),   32'(illegal_o),     32'(vecs[i].e_ill));
      checkOutput($sformatf("row%0d branch_cnt", i),  32'(branch_cnt),    32'(vecs[i].e_bcnt));
      checkOutput($sformatf("row%0d mispred_cnt", i), 32'(mispred_cnt),   32'(vecs[i].e_mcnt));
      checkOutput($sformatf("row%0d if_pred_taken", i), 32'(if_pred_taken), 32'(vecs[i].e_p));
    end

    // Same-cycle lookup and update of entry 8: the lookup sees the old value.
    applyStimulus(mk(1, 1, 3'b000, 32'h120, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("no-bypass pred before edge", 32'(if_pred_taken), 32'd0);
    step();
    checkOutput("no-bypass pred after edge", 32'(if_pred_taken), 32'd1);
    checkOutput("mid-flush flush_o before reset", 32'(flush_o), 32'd1);
    checkOutput("mid-flush mispred_cnt", 32'(mispred_cnt), 32'd7);

    // Reset during the first flush cycle.
    idleInputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("mid-flush reset flush_o",     32'(flush_o),     32'd0);
    checkOutput("mid-flush reset redirect_o",  32'(redirect_o),  32'd0);
    checkOutput("mid-flush reset branch_cnt",  32'(branch_cnt),  32'd0);
    checkOutput("mid-flush reset mispred_cnt", 32'(mispred_cnt), 32'd0);
    step();
    checkOutput("post-reset flush_o stays low", 32'(flush_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'h100 + 32'(i * 4);
      #1;
      checkOutput($sformatf("post-reset pred idx%0d", i), 32'(if_pred_taken), 32'd0);
    end
    // One taken resolve moves a freshly reset entry 01->10, so it predicts taken.
    applyStimulus(mk(1, 1, 3'b000, 32'h120, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    checkOutput("post-reset taken pred", 32'(if_pred_taken), 32'd1);
    checkOutput("post-reset redirect_o", 32'(redirect_o),    32'd1);
    idleInputs();
    step();
    step();

    // Counter wrap: 65536 correctly predicted not-taken BLTUs.
    RST = 1'b1;
    step();
    RST = 1'b0;
    applyStimulus(mk(1, 1, 3'b110, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 65535; i++) step();
    checkOutput("wrap branch_cnt at 65535", 32'(branch_cnt),  32'h0000FFFF);
    checkOutput("wrap mispred_cnt",         32'(mispred_cnt), 32'd0);
    checkOutput("wrap flush_o",             32'(flush_o),     32'd0);
    step();
    checkOutput("wrap branch_cnt to 0",     32'(branch_cnt),  32'd0);
    idleInputs();
    step();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Branch-resolution controller for the pipelined OTTER.
- Holds a 2-bit-counter branch history table (BHT) that the fetch stage uses to predict branches.
- In EX, combines funct3 with the branch comparator flags (br_eq/br_lt/br_ltu) to compute the actual outcome, detects mispredicts, and sequences a multi-cycle flush/redirect of IF/ID.
- Also keeps branch and mispredict statistics counters.

Parameters:
- BHT_ENTRIES, 16, number of BHT entries; power of 2, 4..256.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; derived, do not override.
- FLUSH_CYCLES, 2, cycles flush_o stays high per mispredict; range 1..7.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- if_pc  input  32  fetch PC used for prediction lookup.
- if_pred_taken  output  1  combinational: MSB of BHT[if_pc[IDX_W+1:2]].
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch (opcode 1100011).
- ex_funct3  input  3  branch funct3.
- ex_pc  input  32  PC of the EX instruction.
- ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
- br_eq  input  1  comparator flag: rs1 == rs2.
- br_lt  input  1  comparator flag: signed rs1 < rs2.
- br_ltu  input  1  comparator flag: unsigned rs1 < rs2.
- flush_o  output  1  registered: squash IF/ID.
- redirect_o  output  1  registered, one-cycle pulse: load the PC from the redirect source.
- redirect_taken_o  output  1  registered: 1 = branch target, 0 = ex_pc+4; valid when redirect_o=1.
- illegal_o  output  1  registered, one-cycle pulse: funct3 of 010 or 011 seen on a resolving branch.
- branch_cnt  output  16  branches resolved; wraps at 16 bits.
- mispred_cnt  output  16  mispredicts; wraps at 16 bits.

Behaviour:
- Resolve condition: ex_valid & ex_is_branch & (state==IDLE).
- Outcome "taken" by funct3:
  - 000: br_eq
  - 001: !br_eq
  - 100: br_lt
  - 101: !br_lt
  - 110: br_ltu
  - 111: !br_ltu
  - 010/011: taken=0, illegal_o pulses next cycle; BHT is not updated, branch_cnt is not incremented.
- BHT update on a valid resolve (legal funct3): index = ex_pc[IDX_W+1:2].
  - taken: counter +1, saturating at 11.
  - not taken: counter -1, saturating at 00.
- Lookup/update to the same index in the same cycle: lookup returns the pre-update value (no bypass).
- Mispredict = legal resolve & (taken != ex_pred_taken).
- FSM, state IDLE:
  - On mispredict, next cycle: flush_o=1, redirect_o=1, redirect_taken_o=taken, flush counter = FLUSH_CYCLES-1, mispred_cnt+1, move to FLUSH.
  - If FLUSH_CYCLES==1 and the counter is 0, return to IDLE after one flush cycle.
- FSM, state FLUSH:
  - flush_o=1, redirect_o=0.
  - Counter decrements each cycle; exit to IDLE when it reads 0.
  - All resolves are ignored (wrong-path): no BHT update, no counter change, no illegal_o.
- Correct prediction: no flush; branch_cnt+1 only.
- Latency: resolve cycle N -> flush_o/redirect_o asserted in cycle N+1.
  - flush_o high for exactly FLUSH_CYCLES consecutive cycles.
  - The next resolve is accepted in cycle N+1+FLUSH_CYCLES.
- Back-to-back: a legal resolve in the first IDLE cycle after FLUSH is handled normally.
- Reset (any cycle, including mid-FLUSH), takes effect on the next edge:
  - state=IDLE; flush_o, redirect_o, redirect_taken_o, illegal_o = 0.
  - branch_cnt = mispred_cnt = 0.
  - All BHT entries = 01 (weakly not-taken).
- ex_is_branch=0 or ex_valid=0: no action.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0. Resolve BEQ at ex_pc=0x100, br_eq=1, ex_pred_taken=0 -> next cycle redirect_o=1, redirect_taken_o=1; flush_o high 2 cycles; mispred_cnt=1, branch_cnt=1; BHT[0]=10, so if_pred_taken=1.
- Resolve BLTU (110) at 0x104 with br_ltu=0, br_lt=1, ex_pred_taken=0 -> correct prediction, no flush, branch_cnt+1, BHT[1] 01->00. Then 00 saturates on a further not-taken.
- Three taken BGE (101, br_lt=0) at 0x108 -> BHT[2] goes 01->10->11->11; the third predicts correctly.
- Mispredict, then assert resolves on both FLUSH cycles -> ignored: counters unchanged, flush_o exactly 2 cycles; the resolve in the following cycle is counted.
- funct3=010 resolve -> illegal_o pulses 1 cycle, no flush, branch_cnt unchanged.
- Assert RST in the 1st FLUSH cycle -> next cycle flush_o=0, counters=0, all BHT entries=01. Also drive 65536 correct branches -> branch_cnt wraps to 0.
